// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// Module   : fetch_stage_if
// Purpose  : memory request/response, decode and redirect bus of fetch_stage.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_stage_if #(
  parameter int NUM_LANES = 8
);
  logic                 mem_req_valid;
  logic [63:0]          mem_req_addr;
  logic                 mem_req_ready;
  logic                 mem_rsp_valid;
  logic [31:0]          mem_rsp_data;
  logic                 dec_valid;
  logic [63:0]          dec_pc;
  logic [31:0]          dec_insn;
  logic [NUM_LANES-1:0] dec_exec_mask;
  logic                 dec_busy;
  logic                 redir_valid;
  logic [63:0]          redir_pc;
  logic [NUM_LANES-1:0] redir_exec_mask;

  modport master (
    output mem_req_valid, mem_req_addr,
    input  mem_req_ready,
    input  mem_rsp_valid, mem_rsp_data,
    output dec_valid, dec_pc, dec_insn, dec_exec_mask,
    input  dec_busy,
    input  redir_valid, redir_pc, redir_exec_mask
  );

  modport slave (
    input  mem_req_valid, mem_req_addr,
    output mem_req_ready,
    output mem_rsp_valid, mem_rsp_data,
    input  dec_valid, dec_pc, dec_insn, dec_exec_mask,
    output dec_busy,
    output redir_valid, redir_pc, redir_exec_mask
  );
endinterface

`default_nettype wire

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// Module   : fetch_stage
// Purpose  : single-outstanding instruction fetch with redirect, halt and an
//            optional stall counter enabled by FETCH_PERF_COUNTERS_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_stage #(
  parameter int          CORE_ID   = 0,
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter int          NUM_LANES = 8
) (
  input  wire logic        clk,
  input  wire logic        reset_n,
  fetch_stage_if.master    bus,
  input  wire logic        halt_in,
  output logic             halted,
  output logic [31:0]      perf_stall_cycles
);

  localparam logic [1:0] C_ST_ISSUE  = 2'd0;
  localparam logic [1:0] C_ST_WAIT   = 2'd1;
  localparam logic [1:0] C_ST_SEND   = 2'd2;
  localparam logic [1:0] C_ST_HALTED = 2'd3;

  logic [1:0]           r_state;
  logic [63:0]          r_pc;
  logic [NUM_LANES-1:0] r_mask;
  logic [31:0]          r_insn;
  logic                 r_discard;
  logic                 w_send;
  logic                 unused_core_id;

  assign unused_core_id = (CORE_ID < 0);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state   <= C_ST_ISSUE;
      r_pc      <= RESET_PC;
      r_mask    <= '1;
      r_discard <= 1'b0;
      r_insn    <= '0;
    end else if (halt_in) begin
      r_state <= C_ST_HALTED;
    end else begin
      case (r_state)
        C_ST_ISSUE: begin
          if (bus.redir_valid) begin
            r_pc   <= bus.redir_pc;
            r_mask <= bus.redir_exec_mask;
          end else if (bus.mem_req_ready) begin
            r_state <= C_ST_WAIT;
          end
        end
        C_ST_WAIT: begin
          // A redirect without the response in hand must wait for it and drop it.
          if (bus.redir_valid) begin
            r_pc   <= bus.redir_pc;
            r_mask <= bus.redir_exec_mask;
            if (bus.mem_rsp_valid) begin
              r_discard <= 1'b0;
              r_state   <= C_ST_ISSUE;
            end else begin
              r_discard <= 1'b1;
            end
          end else if (bus.mem_rsp_valid) begin
            if (r_discard) begin
              r_discard <= 1'b0;
              r_state   <= C_ST_ISSUE;
            end else begin
              r_insn  <= bus.mem_rsp_data;
              r_state <= C_ST_SEND;
            end
          end
        end
        C_ST_SEND: begin
          if (bus.redir_valid) begin
            r_pc    <= bus.redir_pc;
            r_mask  <= bus.redir_exec_mask;
            r_state <= C_ST_ISSUE;
          end else if (!bus.dec_busy) begin
            r_pc    <= r_pc + 64'd4;
            r_state <= C_ST_ISSUE;
          end
        end
        C_ST_HALTED: r_state <= C_ST_HALTED;
        default:     r_state <= C_ST_ISSUE;
      endcase
    end
  end

  assign w_send            = (r_state == C_ST_SEND);
  assign bus.mem_req_valid = reset_n && (r_state == C_ST_ISSUE);
  assign bus.mem_req_addr  = r_pc;
  assign bus.dec_valid     = w_send;
  assign bus.dec_pc        = w_send ? r_pc   : '0;
  assign bus.dec_insn      = w_send ? r_insn : '0;
  assign bus.dec_exec_mask = w_send ? r_mask : '0;
  assign halted            = (r_state == C_ST_HALTED);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_perf <= '0;
    end else if (((r_state == C_ST_WAIT) || (w_send && bus.dec_busy)) &&
                 (r_perf != 32'hFFFF_FFFF)) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stall_cycles = r_perf;
`else
  assign perf_stall_cycles = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// Module   : tb_fetch_stage
// Purpose  : directed bench for fetch_stage with a PC-level reference model.
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_fetch_stage;
  localparam int          NL  = 8;
  localparam logic [63:0] RPC = 64'h0;

  logic        clk;
  logic        reset_n;
  logic        halt_in;
  logic        halted;
  logic [31:0] perf;

  fetch_stage_if #(.NUM_LANES(NL)) bus();

  fetch_stage #(.CORE_ID(0), .RESET_PC(RPC), .NUM_LANES(NL)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.master),
    .halt_in(halt_in), .halted(halted), .perf_stall_cycles(perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_fail;

  // Architectural model: fetch PC, lane mask, transaction phase.
  logic [63:0]   m_pc;
  logic [NL-1:0] m_mask;
  logic          m_halted;
  int            m_phase;   // 0 request, 1 awaiting word, 2 holding packet
  logic          m_discard;
  logic [31:0]   m_perf;
  logic          model_ok;

  // Memory responder state.
  int          rsp_lat;
  logic        mem_pend;
  int          mem_cnt;
  logic [63:0] mem_addr;
  logic        seen_req;
  logic [63:0] seen_addr;

  logic          exp_req;
  logic          exp_dv;
  int            cyc;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h0000_0011;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_update();
    if (!reset_n) begin
      m_pc = RPC; m_mask = '1; m_halted = 1'b0; m_phase = 0;
      m_discard = 1'b0; m_perf = '0; model_ok = 1'b1;
    end else if (model_ok && !m_halted) begin
      if ((m_phase == 1 || (m_phase == 2 && bus.dec_busy)) && m_perf != 32'hFFFF_FFFF)
        m_perf = m_perf + 32'd1;
      if (halt_in) begin
        m_halted = 1'b1;
      end else if (bus.redir_valid) begin
        m_pc   = bus.redir_pc;
        m_mask = bus.redir_exec_mask;
        if (m_phase == 1 && !bus.mem_rsp_valid) m_discard = 1'b1;
        else begin m_discard = 1'b0; m_phase = 0; end
      end else begin
        case (m_phase)
          0: if (bus.mem_req_ready) m_phase = 1;
          1: if (bus.mem_rsp_valid) begin m_phase = m_discard ? 0 : 2; m_discard = 1'b0; end
          2: if (!bus.dec_busy) begin m_pc = m_pc + 64'd4; m_phase = 0; end
          default: m_phase = 0;
        endcase
      end
    end
  endtask

  // Advance one clock; update model, then drive the memory response.
  task automatic tick();
    @(posedge clk);
    #1;
    model_update();
    bus.mem_rsp_valid = 1'b0;
    if (!reset_n) mem_pend = 1'b0;
    else if (seen_req) begin mem_pend = 1'b1; mem_cnt = rsp_lat; mem_addr = seen_addr; end
    seen_req = 1'b0;
    if (mem_pend) begin
      if (mem_cnt == 0) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_word(mem_addr);
        mem_pend = 1'b0;
      end else begin
        mem_cnt--;
      end
    end
  endtask

  task automatic wait_dec(input int max);
    int c;
    c = 0;
    while (bus.dec_valid !== 1'b1 && c < max) begin tick(); c++; end
    chk("wait_dec_valid", bus.dec_valid, 1'b1);
  endtask

  // Per-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin
    seen_req  = bus.mem_req_valid && bus.mem_req_ready;
    seen_addr = bus.mem_req_addr;
    if (model_ok) begin
      exp_req = reset_n && !m_halted && (m_phase == 0);
      exp_dv  = !m_halted && (m_phase == 2);
      chk("mem_req_valid", bus.mem_req_valid, exp_req);
      if (exp_req) chk("mem_req_addr", bus.mem_req_addr, m_pc);
      chk("dec_valid", bus.dec_valid, exp_dv);
      chk("dec_pc", bus.dec_pc, exp_dv ? m_pc : 64'h0);
      chk("dec_insn", bus.dec_insn, exp_dv ? mem_word(m_pc) : 32'h0);
      chk("dec_exec_mask", bus.dec_exec_mask, exp_dv ? m_mask : '0);
      chk("halted", halted, m_halted);
`ifdef FETCH_PERF_COUNTERS_EN
      chk("perf_stall_cycles", perf, m_perf);
`else
      chk("perf_stall_cycles", perf, 32'h0);
`endif
    end
  end

  initial begin
    n_vec = 0; n_fail = 0; model_ok = 1'b0; seen_req = 1'b0; mem_pend = 1'b0;
    mem_cnt = 0; mem_addr = '0; rsp_lat = 0; m_phase = 0;
    reset_n = 1'b0; halt_in = 1'b0;
    bus.mem_req_ready = 1'b0; bus.mem_rsp_valid = 1'b0; bus.mem_rsp_data = '0;
    bus.dec_busy = 1'b0; bus.redir_valid = 1'b0; bus.redir_pc = '0; bus.redir_exec_mask = '0;
    tick(); tick();

    // Reset state
    chk("rst_req_valid", bus.mem_req_valid, 1'b0);
    chk("rst_dec_valid", bus.dec_valid, 1'b0);
    chk("rst_dec_pc", bus.dec_pc, 64'h0);
    chk("rst_dec_insn", bus.dec_insn, 32'h0);
    chk("rst_dec_mask", bus.dec_exec_mask, 8'h00);
    chk("rst_halted", halted, 1'b0);
    chk("rst_perf", perf, 32'h0);

    // First fetch: three cycles to decode
    reset_n = 1'b1; bus.mem_req_ready = 1'b1;
    #1;
    chk("first_req_valid", bus.mem_req_valid, 1'b1);
    chk("first_req_addr", bus.mem_req_addr, RPC);
    cyc = 1;
    while (bus.dec_valid !== 1'b1 && cyc < 10) begin tick(); cyc++; end
    chk("first_latency", cyc, 3);
    chk("first_dec_pc", bus.dec_pc, RPC);
    chk("first_dec_insn", bus.dec_insn, 32'h11);
    chk("first_dec_mask", bus.dec_exec_mask, 8'hFF);
    tick();
    chk("second_req_addr", bus.mem_req_addr, RPC + 64'd4);

    // Decode back-pressure for five cycles
    wait_dec(10);
    bus.dec_busy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("busy_hold_valid", bus.dec_valid, 1'b1);
      chk("busy_hold_pc", bus.dec_pc, RPC + 64'd4);
      chk("busy_hold_insn", bus.dec_insn, 32'h15);
    end
    bus.dec_busy = 1'b0;
    tick();
    chk("busy_consumed", bus.dec_valid, 1'b0);
`ifdef FETCH_PERF_COUNTERS_EN
    chk("perf_after_busy", perf, 32'd7);
`else
    chk("perf_after_busy", perf, 32'd0);
`endif
    chk("after_busy_addr", bus.mem_req_addr, RPC + 64'd8);

    // Request held until ready
    bus.mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req_valid", bus.mem_req_valid, 1'b1);
      chk("stall_req_addr", bus.mem_req_addr, RPC + 64'd8);
    end

    // Redirect while waiting; late response dropped
    rsp_lat = 2; bus.mem_req_ready = 1'b1;
    tick();
    bus.redir_valid = 1'b1; bus.redir_pc = 64'h100; bus.redir_exec_mask = 8'h0F;
    tick();
    bus.redir_valid = 1'b0; rsp_lat = 0;
    chk("discard_no_req", bus.mem_req_valid, 1'b0);
    tick();
    chk("discard_rsp_cycle_no_req", bus.mem_req_valid, 1'b0);
    tick();
    chk("redir_req_valid", bus.mem_req_valid, 1'b1);
    chk("redir_req_addr", bus.mem_req_addr, 64'h100);
    wait_dec(10);
    chk("redir_dec_pc", bus.dec_pc, 64'h100);
    chk("redir_dec_mask", bus.dec_exec_mask, 8'h0F);
    chk("redir_dec_insn", bus.dec_insn, 32'h111);

    // Redirect coincident with the response
    tick();
    chk("seq_req_addr", bus.mem_req_addr, 64'h104);
    tick();
    bus.redir_valid = 1'b1; bus.redir_pc = 64'h200; bus.redir_exec_mask = 8'hF0;
    tick();
    bus.redir_valid = 1'b0;
    chk("coinc_req_valid", bus.mem_req_valid, 1'b1);
    chk("coinc_req_addr", bus.mem_req_addr, 64'h200);
    wait_dec(10);
    chk("coinc_dec_insn", bus.dec_insn, 32'h211);
    chk("coinc_dec_mask", bus.dec_exec_mask, 8'hF0);

    // Redirect beats consume; redirect while requesting
    bus.redir_valid = 1'b1; bus.redir_pc = 64'h300; bus.redir_exec_mask = 8'hAA;
    tick();
    bus.redir_valid = 1'b0;
    chk("consume_redir_dv", bus.dec_valid, 1'b0);
    chk("consume_redir_addr", bus.mem_req_addr, 64'h300);
    bus.mem_req_ready = 1'b0;
    bus.redir_valid = 1'b1; bus.redir_pc = 64'h400; bus.redir_exec_mask = 8'h55;
    tick();
    bus.redir_valid = 1'b0; bus.mem_req_ready = 1'b1;
    chk("issue_redir_addr", bus.mem_req_addr, 64'h400);
    wait_dec(10);
    chk("issue_redir_mask", bus.dec_exec_mask, 8'h55);

    // PC wrap
    bus.redir_valid = 1'b1; bus.redir_pc = 64'hFFFF_FFFF_FFFF_FFFC; bus.redir_exec_mask = 8'hFF;
    tick();
    bus.redir_valid = 1'b0;
    wait_dec(10);
    chk("wrap_dec_pc", bus.dec_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_dec_insn", bus.dec_insn, 32'hFFFF_FFED);
    tick();
    chk("wrap_req_addr", bus.mem_req_addr, 64'h0);

    // Reset while a response is outstanding; stray response after reset
    rsp_lat = 3;
    tick();
    reset_n = 1'b0;
    tick();
    chk("midrst_req_valid", bus.mem_req_valid, 1'b0);
    reset_n = 1'b1; rsp_lat = 0;
    bus.mem_rsp_valid = 1'b1; bus.mem_rsp_data = 32'hDEAD_BEEF;
    tick();
    wait_dec(10);
    chk("postrst_dec_pc", bus.dec_pc, RPC);
    chk("postrst_dec_insn", bus.dec_insn, 32'h11);

    // Halt wins over redirect
    halt_in = 1'b1;
    bus.redir_valid = 1'b1; bus.redir_pc = 64'h500; bus.redir_exec_mask = 8'h01;
    tick();
    halt_in = 1'b0; bus.redir_valid = 1'b0;
    chk("halt_halted", halted, 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("halt_no_req", bus.mem_req_valid, 1'b0);
      chk("halt_no_dec", bus.dec_valid, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter CORE_ID, default 0, core identifier used in trace and perf output.
REQ-002 SHALL have parameter RESET_PC, default 64'h0, first fetch address after reset.
REQ-003 SHALL have parameter NUM_LANES, default 8, width of exec_mask.
REQ-004 SHALL have ports: clk in 1, clock; reset_n in 1, synchronous active-low reset.
REQ-005 SHALL have ports: mem_req_valid out 1, fetch request; mem_req_addr out 64, byte address; mem_req_ready in 1, memory accepts request.
REQ-006 SHALL have ports: mem_rsp_valid in 1, response strobe; mem_rsp_data in 32, instruction word.
REQ-007 SHALL have ports: dec_valid out 1, packet to decode; dec_pc out 64; dec_insn out 32; dec_exec_mask out NUM_LANES; dec_busy in 1, decode cannot accept.
REQ-008 SHALL have ports: redir_valid in 1; redir_pc in 64; redir_exec_mask in NUM_LANES (from execute, taken jump or restore-PC).
REQ-009 SHALL have ports: halt_in in 1, execute retired HALT; halted out 1; perf_stall_cycles out 32.
REQ-010 Clock and reset SHALL be one clock, clk, with synchronous active-low reset_n.

Function
REQ-011 States SHALL be ISSUE, WAIT_RSP, SEND, HALTED.
REQ-012 ISSUE: mem_req_valid=1, mem_req_addr=pc; on mem_req_ready go to WAIT_RSP next cycle.
REQ-013 WAIT_RSP: on mem_rsp_valid latch mem_rsp_data into insn register, go to SEND.
REQ-014 SEND: dec_valid=1 with dec_pc=pc, dec_insn, dec_exec_mask=mask; when dec_busy=0 that cycle, the packet is consumed, pc<=pc+4, go to ISSUE.
REQ-015 SEND with dec_busy=1 SHALL hold all dec_* outputs stable.
REQ-016 Minimum latency SHALL be 3 cycles from ISSUE entry to dec_valid with zero-wait memory; one packet in flight, no pipelining.
REQ-017 redir_valid in ISSUE or SEND SHALL load pc<=redir_pc, mask<=redir_exec_mask, drop any unsent packet (dec_valid=0 next cycle) and enter ISSUE.
REQ-018 redir_valid in WAIT_RSP SHALL load pc/mask and set discard flag; the next mem_rsp_valid is dropped, state goes to ISSUE.
REQ-019 redir_valid and mem_rsp_valid in the same WAIT_RSP cycle SHALL drop that response and go to ISSUE.
REQ-020 redir_valid in the same cycle as a SEND consume SHALL win: pc=redir_pc, not pc+4.
REQ-021 halt_in SHALL force HALTED from any state, with priority over redir_valid; HALTED outputs mem_req_valid=0, dec_valid=0, halted=1, exited only by reset.
REQ-022 pc+4 SHALL wrap modulo 2^64.
REQ-023 mem_req_valid SHALL stay asserted with stable address until mem_req_ready.

Reset
REQ-024 When reset_n=0 at a clk edge: state=ISSUE, pc=RESET_PC, mask=all ones, discard=0, insn=0.
REQ-025 During/after reset: mem_req_valid=0 in the reset cycle, dec_valid=0, dec_pc=0, dec_insn=0, dec_exec_mask=0, halted=0, perf_stall_cycles=0.
REQ-026 Reset mid-WAIT_RSP SHALL discard the outstanding response; a mem_rsp_valid in the first cycle after reset is ignored.

Configuration
REQ-027 With FETCH_PERF_COUNTERS_EN defined, perf_stall_cycles SHALL increment by 1 every cycle in WAIT_RSP or in SEND with dec_busy=1, saturating at 32'hFFFFFFFF.
REQ-028 Without FETCH_PERF_COUNTERS_EN, perf_stall_cycles SHALL be constant 0 and no counter logic exists.

Verification
REQ-029 Reset, mem_req_ready=1, rsp next cycle with 32'h00000011, dec_busy=0 -> dec_valid on cycle 3, dec_pc=RESET_PC, dec_insn=32'h11, mask all ones; next req addr RESET_PC+4.
REQ-030 dec_busy=1 for 5 cycles in SEND -> dec_* stable 5 cycles; consumed on the 6th; perf_stall_cycles +5 (macro on), 0 (macro off).
REQ-031 redir_valid (pc 64'h100, mask 8'h0F) in WAIT_RSP, rsp 2 cycles later -> response dropped, next mem_req_addr=64'h100, next packet mask 8'h0F.
REQ-032 redir_valid coincident with SEND consume -> next mem_req_addr=redir_pc, not pc+4.
REQ-033 halt_in with redir_valid same cycle -> HALTED, halted=1, no further mem_req_valid or dec_valid until reset.
REQ-034 pc=64'hFFFFFFFFFFFFFFFC consumed -> next mem_req_addr=64'h0.
